// File: rtl/reg_file_reader_if.sv
// reg_file_reader_if: bundles the write-back, decode-read and stack signals of the register file.
//   master: drives wr_*, rd_en, rd_addr_*, sp_push, sp_pop; observes read data, SP and fault.
//   slave : the register file; drives rd_data_*, rd_valid, sp_addr, sp_value, stack_fault.
interface reg_file_reader_if #(
    parameter int N    = 16,
    parameter int ADDR = 3
);
    logic            wr_en;
    logic [ADDR-1:0] wr_addr;
    logic [N-1:0]    wr_data;
    logic            rd_en;
    logic [ADDR-1:0] rd_addr_a;
    logic [ADDR-1:0] rd_addr_b;
    logic [N-1:0]    rd_data_a;
    logic [N-1:0]    rd_data_b;
    logic            rd_valid;
    logic            sp_push;
    logic            sp_pop;
    logic [N-1:0]    sp_addr;
    logic [N-1:0]    sp_value;
    logic            stack_fault;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, sp_push, sp_pop,
        input  rd_data_a, rd_data_b, rd_valid, sp_addr, sp_value, stack_fault
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b, sp_push, sp_pop,
        output rd_data_a, rd_data_b, rd_valid, sp_addr, sp_value, stack_fault
    );
endinterface

// File: rtl/reg_file_reader.sv
// reg_file_reader: 2^ADDR x N register file with two registered read ports, write-to-read bypass and a stack pointer.
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high, clears registers, read outputs, SP (to SP_RESET) and stack_fault
//   bus   : write-back port, dual read port (1-cycle latency, rd_valid pulse), push/pop with
//           combinational sp_addr, current sp_value and sticky stack_fault
module reg_file_reader #(
    parameter int             N        = 16,
    parameter int             ADDR     = 3,
    parameter logic [N-1:0]   SP_RESET = {N{1'b1}}
) (
    input logic              clk,
    input logic              reset,
    reg_file_reader_if.slave bus
);
    localparam int DEPTH = 1 << ADDR;

    logic [N-1:0] regs_q [DEPTH];
    logic [N-1:0] regs_d [DEPTH];
    logic [N-1:0] rd_data_a_q, rd_data_a_d;
    logic [N-1:0] rd_data_b_q, rd_data_b_d;
    logic         rd_valid_q, rd_valid_d;
    logic [N-1:0] sp_q, sp_d;
    logic         stack_fault_q, stack_fault_d;
    logic         push_only, pop_only;
    logic [N-1:0] byp_a, byp_b;

    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en) regs_d[bus.wr_addr] = bus.wr_data;
    end

    // A register being written this cycle is forwarded so decode sees the new value.
    always_comb begin
        byp_a       = (bus.wr_en && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : regs_q[bus.rd_addr_a];
        byp_b       = (bus.wr_en && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : regs_q[bus.rd_addr_b];
        rd_data_a_d = bus.rd_en ? byp_a : rd_data_a_q;
        rd_data_b_d = bus.rd_en ? byp_b : rd_data_b_q;
        rd_valid_d  = bus.rd_en;
    end

    // Simultaneous push and pop is a no-op on SP but is flagged as a fault.
    // Underflow/overflow still move SP (modulo 2^N) and latch the fault.
    always_comb begin
        push_only     = bus.sp_push & ~bus.sp_pop;
        pop_only      = bus.sp_pop & ~bus.sp_push;
        sp_d          = push_only ? sp_q - 1'b1 : pop_only ? sp_q + 1'b1 : sp_q;
        stack_fault_d = stack_fault_q
                      | (bus.sp_push & bus.sp_pop)
                      | (pop_only & (sp_q == SP_RESET))
                      | (push_only & (sp_q == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd_data_a_q   <= '0;
            rd_data_b_q   <= '0;
            rd_valid_q    <= 1'b0;
            sp_q          <= SP_RESET;
            stack_fault_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            rd_data_a_q   <= rd_data_a_d;
            rd_data_b_q   <= rd_data_b_d;
            rd_valid_q    <= rd_valid_d;
            sp_q          <= sp_d;
            stack_fault_q <= stack_fault_d;
        end
    end

    // Pop reads the slot above SP (pre-increment); push stores at SP (post-decrement).
    assign bus.sp_addr     = pop_only ? sp_q + 1'b1 : sp_q;
    assign bus.sp_value    = sp_q;
    assign bus.rd_data_a   = rd_data_a_q;
    assign bus.rd_data_b   = rd_data_b_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.stack_fault = stack_fault_q;
endmodule

// File: tb/tb_reg_file_reader.sv
// tb_reg_file_reader: directed self-checking bench for reg_file_reader.
module tb_reg_file_reader;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    reg_file_reader_if #(.N(16), .ADDR(3)) bus ();

    reg_file_reader #(.N(16), .ADDR(3), .SP_RESET(16'hFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 1'b0; bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        bus.sp_push = 1'b0; bus.sp_pop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("reset_valid", {15'd0, bus.rd_valid}, 16'd0);
        chk("reset_rda", bus.rd_data_a, 16'h0000);
        chk("reset_sp", bus.sp_value, 16'hFFFF);
        chk("reset_spaddr", bus.sp_addr, 16'hFFFF);
        chk("reset_fault", {15'd0, bus.stack_fault}, 16'd0);

        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd3; bus.rd_addr_b = 3'd7;
        step();
        bus.rd_en = 1'b0;
        chk("rd0_a", bus.rd_data_a, 16'h0000);
        chk("rd0_b", bus.rd_data_b, 16'h0000);
        chk("rd0_valid", {15'd0, bus.rd_valid}, 16'd1);
        chk("rd0_sp", bus.sp_value, 16'hFFFF);
        chk("rd0_fault", {15'd0, bus.stack_fault}, 16'd0);

        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'hA5A5;
        step();
        bus.wr_en = 1'b0;
        chk("gap_valid", {15'd0, bus.rd_valid}, 16'd0);
        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd2; bus.rd_addr_b = 3'd0;
        step();
        bus.rd_en = 1'b0;
        chk("wr_rd_a", bus.rd_data_a, 16'hA5A5);
        chk("wr_rd_b", bus.rd_data_b, 16'h0000);
        chk("wr_rd_valid", {15'd0, bus.rd_valid}, 16'd1);
        step();
        chk("hold_valid", {15'd0, bus.rd_valid}, 16'd0);
        chk("hold_a", bus.rd_data_a, 16'hA5A5);

        bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 16'h1111;
        step();
        bus.wr_data = 16'h1234;
        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd5; bus.rd_addr_b = 3'd5;
        step();
        bus.wr_en = 1'b0;
        chk("byp_a", bus.rd_data_a, 16'h1234);
        chk("byp_b", bus.rd_data_b, 16'h1234);
        bus.rd_addr_b = 3'd2;
        step();
        bus.rd_en = 1'b0;
        chk("r5_a", bus.rd_data_a, 16'h1234);
        chk("r2_b", bus.rd_data_b, 16'hA5A5);

        bus.sp_push = 1'b1;
        #1 chk("push1_addr", bus.sp_addr, 16'hFFFF);
        step();
        chk("push1_sp", bus.sp_value, 16'hFFFE);
        chk("push2_addr", bus.sp_addr, 16'hFFFE);
        step();
        bus.sp_push = 1'b0;
        chk("push2_sp", bus.sp_value, 16'hFFFD);
        bus.sp_pop = 1'b1;
        #1 chk("pop1_addr", bus.sp_addr, 16'hFFFE);
        step();
        chk("pop1_sp", bus.sp_value, 16'hFFFE);
        chk("pop2_addr", bus.sp_addr, 16'hFFFF);
        step();
        chk("pop2_sp", bus.sp_value, 16'hFFFF);
        chk("stack_fault0", {15'd0, bus.stack_fault}, 16'd0);

        chk("uf_addr", bus.sp_addr, 16'h0000);
        step();
        chk("uf_sp", bus.sp_value, 16'h0000);
        chk("uf_fault", {15'd0, bus.stack_fault}, 16'd1);
        step();
        bus.sp_pop = 1'b0;
        chk("uf_legal_sp", bus.sp_value, 16'h0001);
        chk("uf_sticky", {15'd0, bus.stack_fault}, 16'd1);
        step();
        chk("uf_idle_sticky", {15'd0, bus.stack_fault}, 16'd1);

        #2 reset = 1'b1;
        #1 chk("rst_fault", {15'd0, bus.stack_fault}, 16'd0);
        chk("rst_sp", bus.sp_value, 16'hFFFF);
        @(negedge clk);
        reset = 1'b0;
        bus.sp_push = 1'b1; bus.sp_pop = 1'b1;
        #1 chk("both_addr", bus.sp_addr, 16'hFFFF);
        step();
        bus.sp_push = 1'b0; bus.sp_pop = 1'b0;
        chk("both_sp", bus.sp_value, 16'hFFFF);
        chk("both_fault", {15'd0, bus.stack_fault}, 16'd1);
        reset = 1'b1;
        #1 chk("both_rst_fault", {15'd0, bus.stack_fault}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 16'hBEEF;
        step();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1; bus.rd_addr_a = 3'd4;
        step();
        chk("r4_a", bus.rd_data_a, 16'hBEEF);
        chk("r4_valid", {15'd0, bus.rd_valid}, 16'd1);
        #2 reset = 1'b1;
        #1 chk("async_a", bus.rd_data_a, 16'h0000);
        chk("async_valid", {15'd0, bus.rd_valid}, 16'd0);
        step();
        chk("held_valid", {15'd0, bus.rd_valid}, 16'd0);
        bus.rd_en = 1'b0;
        reset = 1'b0;
        step();
        chk("post_valid", {15'd0, bus.rd_valid}, 16'd0);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("r4_cleared", bus.rd_data_a, 16'h0000);
        chk("r4_cleared_valid", {15'd0, bus.rd_valid}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
